// File: rtl/reg_desp_universal_pkg.sv
// Shared mode/direction encodings for the universal shift register and its bit cells.
package reg_desp_universal_pkg;

    localparam logic [1:0] MODO_SHIFT = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_LOAD  = 2'b10;

    localparam logic DIR_MSB = 1'b1;
    localparam logic DIR_LSB = 1'b0;

    // Any MODO with the high bit set is a parallel load.
    function automatic logic is_load(input logic [1:0] modo);
        return modo[1];
    endfunction

endpackage

// File: rtl/reg_desp_universal_celda_desp.sv
// One bit cell: next-value selector (load / neighbour / serial-in) plus its storage flop.
module celda_desp
    import reg_desp_universal_pkg::*;
#(
    parameter bit IS_LSB = 1'b0,
    parameter bit IS_MSB = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic       ENB,
    input  logic       DIR,
    input  logic [1:0] MODO,
    input  logic       Di,
    input  logic       S_IN,
    input  logic       izq,
    input  logic       der,
    output logic       Q
);

    logic q_q;
    logic q_d;
    logic edge_cell;

    // At the end the data enters from, serial shift takes S_IN instead of the wrapped neighbour.
    assign edge_cell = (DIR == DIR_MSB) ? IS_LSB : IS_MSB;

    always_comb begin
        q_d = q_q;
        if (ENB) begin
            if (is_load(MODO)) begin
                q_d = Di;
            end else if ((MODO == MODO_SHIFT) && edge_cell) begin
                q_d = S_IN;
            end else begin
                q_d = (DIR == DIR_MSB) ? izq : der;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/reg_desp_universal.sv
// Universal shift register (shift/rotate/load/hold) with shift counter and full-shift pulse.
module reg_desp_universal
    import reg_desp_universal_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             DIR,
    input  logic [1:0]       MODO,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic [CNT_W-1:0] CNT,
    output logic             FULL_SHIFT
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_w;

    // Bit cells; the end cells wrap to the opposite end for rotate.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        logic izq;
        logic der;

        if (i == 0) begin : g_izq_wrap
            assign izq = q_w[WIDTH-1];
        end else begin : g_izq
            assign izq = q_w[i-1];
        end

        if (i == int'(WIDTH) - 1) begin : g_der_wrap
            assign der = q_w[0];
        end else begin : g_der
            assign der = q_w[i+1];
        end

        celda_desp #(
            .IS_LSB (i == 0),
            .IS_MSB (i == int'(WIDTH) - 1)
        ) u_celda (
            .CLK     (CLK),
            .RESET_L (RESET_L),
            .ENB     (ENB),
            .DIR     (DIR),
            .MODO    (MODO),
            .Di      (D[i]),
            .S_IN    (S_IN),
            .izq     (izq),
            .der     (der),
            .Q       (q_w[i])
        );
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             full_q, full_d;
    logic             move_c;
    logic             load_c;

    assign load_c = ENB && is_load(MODO);
    assign move_c = ENB && !is_load(MODO);

    // Counter, serial output and full-shift pulse next-state.
    always_comb begin
        cnt_d   = cnt_q;
        s_out_d = s_out_q;
        full_d  = 1'b0;
        if (load_c) begin
            cnt_d   = '0;
            s_out_d = 1'b0;
        end else if (move_c) begin
            s_out_d = (DIR == DIR_MSB) ? q_w[WIDTH-1] : q_w[0];
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            full_d = (cnt_q == CNT_PRE);
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            cnt_q   <= '0;
            s_out_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            s_out_q <= s_out_d;
            full_q  <= full_d;
        end
    end

    assign Q          = q_w;
    assign S_OUT      = s_out_q;
    assign CNT        = cnt_q;
    assign FULL_SHIFT = full_q;

endmodule
